// File: rtl/swizzle_pkg.sv
// Shared types and defaults for the swizzle permutation pipeline.
package swizzle_pkg;

    typedef enum logic [1:0] {
        BIT_REV      = 2'd0,
        LANE_REV     = 2'd1,
        LANE_BIT_REV = 2'd2,
        ROT_L        = 2'd3
    } mode_e;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_LANE  = 8;

    function automatic int unsigned AMT_W(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/swizzle_perm.sv
// Combinational bit-permutation core: bit reverse, lane reverse,
// bit reverse within lanes, and rotate-left.
module swizzle_perm
    import swizzle_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned LANE  = DEFAULT_LANE
) (
    input  logic [WIDTH-1:0]          data,
    input  mode_e                     mode,
    input  logic [AMT_W(WIDTH)-1:0]   amt,
    output logic [WIDTH-1:0]          result
);

    localparam int unsigned NL = WIDTH / LANE;

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("swizzle_perm: WIDTH must be a power of two >= 2");
    end
    if (LANE < 1 || (WIDTH % LANE) != 0) begin : g_bad_lane
        $error("swizzle_perm: LANE must be >= 1 and divide WIDTH");
    end

    logic [2*WIDTH-1:0] rot_dbl;

    always_comb begin
        result  = '0;
        // Upper half of the shifted doubled word is the left rotation.
        rot_dbl = {data, data} << amt;
        case (mode)
            BIT_REV: begin
                for (int unsigned i = 0; i < WIDTH; i++)
                    result[i] = data[WIDTH-1-i];
            end
            LANE_REV: begin
                for (int unsigned k = 0; k < NL; k++)
                    result[k*LANE +: LANE] = data[(NL-1-k)*LANE +: LANE];
            end
            LANE_BIT_REV: begin
                for (int unsigned k = 0; k < NL; k++)
                    for (int unsigned b = 0; b < LANE; b++)
                        result[k*LANE + b] = data[k*LANE + LANE - 1 - b];
            end
            ROT_L: begin
                result = rot_dbl[2*WIDTH-1 -: WIDTH];
            end
            default: result = data;
        endcase
    end

endmodule

// File: rtl/swizzle_pipe.sv
// Two-stage valid/ready permutation pipeline around swizzle_perm.
// Optional parity self-check enabled by defining SWIZZLE_PIPE_CHECK_EN.
module swizzle_pipe
    import swizzle_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned LANE  = DEFAULT_LANE
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [1:0]                in_mode,
    input  logic [AMT_W(WIDTH)-1:0]   in_amt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [1:0]                out_mode,
    output logic                      out_perr
);

    localparam int unsigned AW = AMT_W(WIDTH);

    logic             s1_valid, s2_valid;
    logic             s1_load, s2_load;
    logic [WIDTH-1:0] s1_data, s2_data, perm_data;
    mode_e            s1_mode, s2_mode;
    logic [AW-1:0]    s1_amt;

    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= BIT_REV;
            s1_amt   <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_mode <= mode_e'(in_mode);
                s1_amt  <= in_amt;
            end
        end
    end

    swizzle_perm #(.WIDTH(WIDTH), .LANE(LANE)) u_perm (
        .data   (s1_data),
        .mode   (s1_mode),
        .amt    (s1_amt),
        .result (perm_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_mode  <= BIT_REV;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= perm_data;
                s2_mode <= s1_mode;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_mode  = s2_mode;

`ifdef SWIZZLE_PIPE_CHECK_EN
    logic s1_par, s2_par;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_par <= 1'b0;
            s2_par <= 1'b0;
        end else begin
            if (s1_load && in_valid) s1_par <= ^in_data;
            if (s2_load && s1_valid) s2_par <= s1_par;
        end
    end

    // Every mode is a pure permutation, so parity must survive the core.
    assign out_perr = s2_valid && ((^s2_data) != s2_par);
`else
    assign out_perr = 1'b0;
`endif

endmodule

// File: tb/tb_swizzle_pipe.sv
// Directed self-checking bench for swizzle_pipe (WIDTH=32, LANE=8).
module tb_swizzle_pipe;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_mode;
    logic [4:0]  in_amt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_mode;
    logic        out_perr;

    swizzle_pipe #(.WIDTH(32), .LANE(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .out_perr  (out_perr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    logic        fired;
    logic        hold_pend = 1'b0;
    logic [31:0] hold_data;
    logic [1:0]  hold_mode;
    logic [33:0] exp_q[$];
    logic [31:0] got_q[$];
    int unsigned got_cyc[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference permutation written independently of the RTL structure.
    function automatic logic [31:0] model(input logic [31:0] d, input logic [1:0] m,
                                          input logic [4:0] a);
        logic [31:0] r;
        r = '0;
        case (m)
            2'd0: for (int i = 0; i < 32; i++) r[i] = d[31-i];
            2'd1: for (int i = 0; i < 32; i++) r[i] = d[(3 - i/8)*8 + i%8];
            2'd2: for (int i = 0; i < 32; i++) r[i] = d[(i/8)*8 + 7 - i%8];
            default: for (int i = 0; i < 32; i++) r[(i + int'(a)) % 32] = d[i];
        endcase
        return r;
    endfunction

    // One clock cycle: drive inputs at the falling edge, observe, scoreboard.
    task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] m,
                         input logic [4:0] a, input logic ordy);
        logic [33:0] e;
        in_valid  = v;
        in_data   = d;
        in_mode   = m;
        in_amt    = a;
        out_ready = ordy;
        #1;
        if (hold_pend) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'(out_data), 64'(hold_data));
            check("hold_mode", 64'(out_mode), 64'(hold_mode));
        end
        check("perr", 64'(out_perr), 64'd0);
        fired     = 1'b0;
        hold_pend = !reset && out_valid && !out_ready;
        hold_data = out_data;
        hold_mode = out_mode;
        if (!reset) begin
            if (in_valid && in_ready) begin
                exp_q.push_back({m, model(d, m, a)});
                fired = 1'b1;
            end
            if (out_valid && out_ready) begin
                check("out_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e[31:0]));
                    check("out_mode", 64'(out_mode), 64'(e[33:32]));
                end
                got_q.push_back(out_data);
                got_cyc.push_back(cyc);
            end
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) drive(1'b0, '0, 2'd0, '0, 1'b1);
    endtask

    initial begin
        int unsigned start;
        int unsigned nacc;
        int unsigned nsent;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
        in_amt    = '0;
        out_ready = 1'b1;
        @(negedge clock);
        idle(2);
        reset = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_mode", 64'(out_mode), 64'd0);
        check("rst_out_perr", 64'(out_perr), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clock);

        // Single BIT_REV beat, two-cycle latency.
        drive(1'b1, 32'h0000_0001, 2'd0, 5'd0, 1'b1);
        check("t1_fire", 64'(fired), 64'd1);
        check("t1_lat1_valid", 64'(out_valid), 64'd0);
        idle(1);
        check("t1_lat2_valid", 64'(out_valid), 64'd1);
        check("t1_data", 64'(out_data), 64'h8000_0000);
        check("t1_mode", 64'(out_mode), 64'd0);
        idle(2);

        // Four modes back-to-back at full throughput.
        got_q.delete();
        got_cyc.delete();
        start = cyc;
        drive(1'b1, 32'h1122_3344, 2'd1, 5'd0, 1'b1);
        drive(1'b1, 32'h0102_0380, 2'd2, 5'd0, 1'b1);
        drive(1'b1, 32'h1234_5678, 2'd3, 5'd4, 1'b1);
        drive(1'b1, 32'hDEAD_BEEF, 2'd3, 5'd0, 1'b1);
        idle(4);
        check("b2b_count", 64'(got_q.size()), 64'd4);
        if (got_q.size() == 4) begin
            check("b2b_lane_rev", 64'(got_q[0]), 64'h4433_2211);
            check("b2b_lane_bit_rev", 64'(got_q[1]), 64'h8040_C001);
            check("b2b_rot4", 64'(got_q[2]), 64'h2345_6781);
            check("b2b_rot0", 64'(got_q[3]), 64'hDEAD_BEEF);
            for (int unsigned i = 0; i < 4; i++)
                check("b2b_cycle", 64'(got_cyc[i]), 64'(start + 2 + i));
        end

        // Backpressure: only two beats fit with out_ready low.
        got_q.delete();
        nacc = 0;
        for (int unsigned i = 0; i < 6; i++) begin
            drive(1'b1, 32'hA0 + nacc, 2'd0, 5'd0, 1'b0);
            if (fired) nacc++;
        end
        check("bp_accepted", 64'(nacc), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        for (int unsigned i = 0; i < 20 && nacc < 4; i++) begin
            drive(1'b1, 32'hA0 + nacc, 2'd0, 5'd0, 1'b1);
            if (fired) nacc++;
        end
        check("bp_release_accepted", 64'(nacc), 64'd4);
        idle(4);
        check("bp_count", 64'(got_q.size()), 64'd4);
        if (got_q.size() == 4) begin
            check("bp_a0", 64'(got_q[0]), 64'h0500_0000);
            check("bp_a1", 64'(got_q[1]), 64'h8500_0000);
            check("bp_a2", 64'(got_q[2]), 64'h4500_0000);
            check("bp_a3", 64'(got_q[3]), 64'hC500_0000);
        end

        // Alternating stalls with random beats across all modes.
        got_q.delete();
        nsent = 0;
        for (int unsigned i = 0; i < 5000 && nsent < 1000; i++) begin
            drive(1'b1, $urandom, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                  (i % 2) == 0);
            if (fired) nsent++;
        end
        idle(6);
        check("rand_sent", 64'(nsent), 64'd1000);
        check("rand_received", 64'(got_q.size()), 64'd1000);
        check("rand_drained", 64'(exp_q.size()), 64'd0);

        // Reset with both stages full discards in-flight beats.
        got_q.delete();
        for (int unsigned i = 0; i < 4; i++)
            drive(1'b1, 32'h5555_0000 + i, 2'd3, 5'd1, 1'b0);
        check("mid_full_in_ready", 64'(in_ready), 64'd0);
        check("mid_full_out_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        drive(1'b0, '0, 2'd0, '0, 1'b0);
        exp_q.delete();
        reset = 1'b0;
        check("mid_after_out_valid", 64'(out_valid), 64'd0);
        #1;
        check("mid_after_in_ready", 64'(in_ready), 64'd1);
        @(negedge clock);
        idle(6);
        check("mid_no_stale", 64'(got_q.size()), 64'd0);
        drive(1'b1, 32'h00FF_00FF, 2'd3, 5'd8, 1'b1);
        idle(3);
        check("mid_post_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() == 1)
            check("mid_post_data", 64'(got_q[0]), 64'hFF00_FF00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/swizzle_pipe.md
Name: swizzle_pipe

Overview:
Parametrised, pipelined multi-mode bit permutation unit with valid/ready handshakes on both sides. Each beat carries data plus a per-beat mode (full bit reverse, lane reverse, bit reverse within lanes, rotate-left). Two-stage pipeline at full throughput with backpressure. Used as a datapath microbenchmark and as a reusable permutation stage between streaming blocks.

Parameters:
WIDTH, 32, data width in bits; >= 2 and a power of two (elaboration error otherwise).
LANE, 8, lane width in bits for lane modes; WIDTH % LANE == 0 and LANE >= 1 (elaboration error otherwise).

Ports:
clock  input  1  sole clock, rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  upstream beat valid.
in_ready  output  1  block accepts the beat this cycle.
in_data  input  WIDTH  beat payload.
in_mode  input  2  0 BIT_REV, 1 LANE_REV, 2 LANE_BIT_REV, 3 ROT_L.
in_amt  input  $clog2(WIDTH)  rotate amount; used only in ROT_L.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
out_data  output  WIDTH  permuted payload.
out_mode  output  2  mode the result was computed with.
out_perr  output  1  parity-check error flag (see Optional Feature).

Behaviour:
- Reset is synchronous and active-high on clock. While reset is high at a rising edge, both stage valids clear. After reset: out_valid=0, out_data=0, out_mode=0, out_perr=0. in_ready=1 in the first cycle after reset deasserts.
- Transfers: input fires when in_valid && in_ready. Output fires when out_valid && out_ready.
- Stage 1 (S1) registers data, mode, amt and valid. Stage 2 (S2) registers the permuted result, mode and valid. Permutation logic sits between S1 and S2.
- Advance rules: S2 loads when !s2_valid || out_ready. S1 loads when !s1_valid || s2 loads. in_ready equals the S1 load condition, so it depends combinationally on out_ready. No combinational path from in_* to out_*.
- Latency: 2 cycles from input fire to out_valid. Throughput is 1 beat/cycle while out_ready=1.
- Capacity: 2 beats. With out_ready=0, in_ready drops only after both stages are full. Beats are never dropped or duplicated, and order is preserved.
- Register hold: out_data, out_mode and out_perr hold stable while out_valid && !out_ready. Data registers hold their value when not loading (no clearing on drain).
- Mode definitions:
  - BIT_REV: out[i] = in[WIDTH-1-i].
  - LANE_REV: lane k of the output = lane (WIDTH/LANE-1-k) of the input; bits within a lane unchanged.
  - LANE_BIT_REV: each lane is bit-reversed in place.
  - ROT_L: rotate left by in_amt. in_amt is naturally modulo WIDTH. amt=0 passes data through.
- Degenerate parameter cases: with LANE==WIDTH, LANE_REV is identity and LANE_BIT_REV equals BIT_REV. With LANE==1, LANE_REV equals BIT_REV and LANE_BIT_REV is identity.
- Reset mid-operation: in-flight beats are discarded. No output fires in the reset cycle or the cycle after.

Optional Feature:
Macro: SWIZZLE_PIPE_CHECK_EN.
- Defined: S1 also registers the XOR-reduce of in_data, and S2 carries it. out_perr = (^out_data) != carried parity, valid only when out_valid. This flags permutation-core faults; all modes preserve popcount, so out_perr must always read 0 in a correct design.
- Not defined: out_perr is tied to 0 and the parity registers are absent. The port list is identical either way.

Decomposition:
- Package swizzle_pkg:
  - mode_e enum (BIT_REV, LANE_REV, LANE_BIT_REV, ROT_L; 2 bits).
  - Default WIDTH/LANE localparams.
  - AMT_W function returning $clog2(WIDTH).
- Sub-module swizzle_perm: purely combinational core (data, mode, amt -> result), parametrised by WIDTH/LANE. It is instantiated once between S1 and S2 and is unit-testable standalone.

Test Plan:
- WIDTH=32, LANE=8, out_ready=1: BIT_REV 0x00000001 -> 0x80000000 exactly 2 cycles after fire, out_mode=0.
- LANE_REV 0x11223344 -> 0x44332211. LANE_BIT_REV 0x01020380 -> 0x8040C001. ROT_L amt=4 0x12345678 -> 0x23456781. ROT_L amt=0 -> unchanged. Sent back-to-back: 4 results in 4 consecutive cycles.
- Backpressure: out_ready=0 for 6 cycles while in_valid=1 with beats 0xA0..0xA3 in mode BIT_REV. Exactly 2 accepted, in_ready=0 afterwards. Release: results for 0xA0..0xA3 emerge in order, none lost or duplicated.
- Stall hold: out_ready toggling 1/0 each cycle with random beats. out_data stable on every stalled cycle. Sequence matches a reference model after 1000 beats.
- Reset mid-stream: assert reset with both stages full. out_valid=0 the cycle after, no stale output emerges later, in_ready=1 after release.
- With SWIZZLE_PIPE_CHECK_EN, 1000 random beats across all modes -> out_perr never 1. Without the macro, out_perr is constant 0.
